// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================
// core_pkg: shared encodings for the RV32IM pipeline stages
// Rev 1.0
// ============================================================
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_ctrl_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rf_we;
    logic [31:0] alu_result;
    logic [31:0] pc_plus;
    logic [1:0]  result_src;
    logic        dm_we;
    logic [2:0]  funct3;
    logic [31:0] store_data;
  } ex_out_t;

  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] wb,
                                          input logic [31:0] mem);
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================
// divider_seq: 32-iteration restoring divider, DIV/DIVU/REM/REMU
// Rev 1.0
// ============================================================
module divider_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        neg_quo_q, neg_rem_q, is_rem_q;

  logic        signed_op, is_rem, a_neg, b_neg;
  logic        div_zero, overflow, special;
  logic [31:0] a_mag, b_mag, special_res, quo_fix, rem_fix;
  logic [32:0] rem_shift, trial;

  // op[0] selects unsigned, op[1] selects remainder (funct3[1:0])
  assign signed_op = ~op[0];
  assign is_rem    = op[1];
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;

  assign div_zero    = (b == 32'd0);
  assign overflow    = signed_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign special     = div_zero | overflow;
  assign special_res = div_zero ? (is_rem ? a : 32'hFFFF_FFFF)
                                : (is_rem ? 32'd0 : 32'h8000_0000);

  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  assign quo_fix = neg_quo_q ? (32'd0 - quo_q) : quo_q;
  assign rem_fix = neg_rem_q ? (32'd0 - rem_q) : rem_q;

  assign busy   = !rst && !abort &&
                  (((state_q == DIV_IDLE) && start && !special) || (state_q == DIV_BUSY));
  assign done   = (state_q == DIV_DONE);
  assign result = done ? (is_rem_q ? rem_fix : quo_fix) : special_res;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= DIV_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start && !special) begin
            state_q   <= DIV_BUSY;
            cnt_q     <= 5'd31;
            quo_q     <= a_mag;
            rem_q     <= 32'd0;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            is_rem_q  <= is_rem;
          end
        end
        DIV_BUSY: begin
          // trial[32] set means the subtraction went negative: restore
          if (!trial[32]) begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= rem_shift[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          if (cnt_q == 5'd0) state_q <= DIV_DONE;
          else               cnt_q   <= cnt_q - 5'd1;
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/stage_execute.sv
`default_nettype none
// ============================================================
// stage_execute: RV32IM execute stage (ALU, MUL, branch, DIV)
// Rev 1.0
// ============================================================
module stage_execute
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            decode_valid,
  input  logic [XLEN-1:0] decode_rs1_data,
  input  logic [XLEN-1:0] decode_rs2_data,
  input  logic [XLEN-1:0] decode_imm,
  input  logic [XLEN-1:0] decode_instr_addr,
  input  logic [XLEN-1:0] decode_instr_addr_plus,
  input  logic [3:0]      decode_alu_ctrl,
  input  logic            decode_alu_src,
  input  logic            decode_muldiv,
  input  logic [2:0]      decode_funct3,
  input  logic            decode_branch,
  input  logic            decode_jump,
  input  logic            decode_jalr,
  input  logic [4:0]      decode_rd,
  input  logic            decode_regfile_wr_enable,
  input  logic            decode_datamem_wr_enable,
  input  logic [1:0]      decode_result_src,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] mem_alu_result,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic [4:0]      execute_rd,
  output logic            execute_regfile_wr_enable,
  output logic [XLEN-1:0] execute_alu_result,
  output logic [XLEN-1:0] execute_instr_addr_plus,
  output logic [1:0]      execute_result_src,
  output logic            execute_datamem_wr_enable,
  output logic [2:0]      execute_funct3,
  output logic [XLEN-1:0] execute_wr_datamem_data
);

  alu_ctrl_e       alu_op;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_b, alu_res, exe_res, jalr_sum;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
  logic [XLEN-1:0] mul_res, div_res;
  logic            mul_a_signed, mul_b_signed, taken, div_start, div_busy, div_done;
  ex_out_t         ex_d, ex_q;

  assign alu_op  = alu_ctrl_e'(decode_alu_ctrl);
  assign rs1_fwd = fwd_mux(forward_a, decode_rs1_data, wb_result, mem_alu_result);
  assign rs2_fwd = fwd_mux(forward_b, decode_rs2_data, wb_result, mem_alu_result);
  assign op_b    = decode_alu_src ? decode_imm : rs2_fwd;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:   alu_res = rs1_fwd + op_b;
      ALU_SUB:   alu_res = rs1_fwd - op_b;
      ALU_AND:   alu_res = rs1_fwd & op_b;
      ALU_OR:    alu_res = rs1_fwd | op_b;
      ALU_XOR:   alu_res = rs1_fwd ^ op_b;
      ALU_SLL:   alu_res = rs1_fwd << op_b[4:0];
      ALU_SRL:   alu_res = rs1_fwd >> op_b[4:0];
      ALU_SRA:   alu_res = $signed(rs1_fwd) >>> op_b[4:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_fwd) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, rs1_fwd < op_b};
      ALU_PASSB: alu_res = op_b;
      ALU_AUIPC: alu_res = decode_instr_addr + op_b;
      default:   alu_res = '0;
    endcase
  end

  // Sign-extending to 2*XLEN lets one unsigned product serve all four MUL flavours
  assign mul_a_signed = !(decode_funct3[1] && decode_funct3[0]);
  assign mul_b_signed = !decode_funct3[1];
  assign mul_a_ext    = {{XLEN{mul_a_signed & rs1_fwd[XLEN-1]}}, rs1_fwd};
  assign mul_b_ext    = {{XLEN{mul_b_signed & rs2_fwd[XLEN-1]}}, rs2_fwd};
  assign prod         = mul_a_ext * mul_b_ext;
  assign mul_res      = (decode_funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign div_start = decode_valid && decode_muldiv && decode_funct3[2] && ENABLE_M && !flush;

  divider_seq u_divider (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (div_start),
    .op     (decode_funct3[1:0]),
    .a      (rs1_fwd),
    .b      (rs2_fwd),
    .busy   (div_busy),
    .done   (div_done),
    .result (div_res)
  );

  always_comb begin
    taken = 1'b0;
    case (decode_funct3)
      F3_BEQ:  taken = (rs1_fwd == rs2_fwd);
      F3_BNE:  taken = (rs1_fwd != rs2_fwd);
      F3_BLT:  taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      F3_BGE:  taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      F3_BLTU: taken = (rs1_fwd <  rs2_fwd);
      F3_BGEU: taken = (rs1_fwd >= rs2_fwd);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum      = rs1_fwd + decode_imm;
  assign branch_target = decode_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (decode_instr_addr + decode_imm);
  assign stall         = div_busy;
  assign pc_src        = !rst && !flush && decode_valid && !stall &&
                         (decode_jump || (decode_branch && taken));

  always_comb begin
    exe_res = alu_res;
    if (decode_muldiv) exe_res = !ENABLE_M ? '0 : (decode_funct3[2] ? div_res : mul_res);
  end

  always_comb begin
    ex_d = '0;
    if (decode_valid && !stall) begin
      ex_d.rd         = decode_rd;
      ex_d.rf_we      = decode_regfile_wr_enable;
      ex_d.alu_result = exe_res;
      ex_d.pc_plus    = decode_instr_addr_plus;
      ex_d.result_src = decode_result_src;
      ex_d.dm_we      = decode_datamem_wr_enable;
      ex_d.funct3     = decode_funct3;
      ex_d.store_data = rs2_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) ex_q <= '0;
    else              ex_q <= ex_d;
  end

  assign execute_rd                = ex_q.rd;
  assign execute_regfile_wr_enable = ex_q.rf_we;
  assign execute_alu_result        = ex_q.alu_result;
  assign execute_instr_addr_plus   = ex_q.pc_plus;
  assign execute_result_src        = ex_q.result_src;
  assign execute_datamem_wr_enable = ex_q.dm_we;
  assign execute_funct3            = ex_q.funct3;
  assign execute_wr_datamem_data   = ex_q.store_data;

endmodule
`default_nettype wire

// File: doc/stage_execute.md
# stage_execute

Execute stage of the five-stage RV32IM core, between decode and `stage_memory`. It selects forwarded operands and runs the RV32I ALU and single-cycle multiplier. It resolves branches and jumps, and runs a sequential 32-iteration divider that stalls the front of the pipeline. Its registered outputs are the `execute_*` inputs consumed by the memory stage.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `ENABLE_M`, 1: when 0, M-extension ops return 0 and never stall.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: squash the instruction in this stage (from hazard unit).
- `decode_valid` in 1: decode holds a real instruction.
- `decode_rs1_data`, `decode_rs2_data` in 32: register file read data.
- `decode_imm` in 32: sign-extended immediate.
- `decode_instr_addr`, `decode_instr_addr_plus` in 32: PC and PC+4.
- `decode_alu_ctrl` in 4: ALU op.
- `decode_alu_src` in 1: 1 = operand B is the immediate.
- `decode_muldiv` in 1: M-extension op, selected by funct3.
- `decode_funct3` in 3: funct3 field.
- `decode_branch`, `decode_jump`, `decode_jalr` in 1: control-flow type.
- `decode_rd` in 5, `decode_regfile_wr_enable` in 1, `decode_datamem_wr_enable` in 1, `decode_result_src` in 2: passthrough controls.
- `forward_a`, `forward_b` in 2: 00 = regfile, 01 = `wb_result`, 10 = `mem_alu_result`.
- `wb_result`, `mem_alu_result` in 32: forwarding sources.
- `stall` out 1: freeze IF/ID and PC (combinational).
- `pc_src` out 1: redirect fetch (combinational).
- `branch_target` out 32: redirect address (combinational).
- `execute_rd` out 5, `execute_regfile_wr_enable` out 1, `execute_alu_result` out 32, `execute_instr_addr_plus` out 32, `execute_result_src` out 2, `execute_datamem_wr_enable` out 1, `execute_funct3` out 3, `execute_wr_datamem_data` out 32: registered outputs to memory stage.

## Operation
- **Operand A:** forward mux on rs1.
- **Operand B:** forward mux on rs2, then the immediate if `decode_alu_src`.
- **Store data:** `execute_wr_datamem_data` is the forwarded rs2, never the immediate.
- **ALU ops:** ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASSB (LUI); AUIPC via ADD with A = PC. Shift amount is B[4:0].
- **Multiply:** MUL, MULH, MULHSU, MULHU from one 64-bit product computed in one cycle.
- **Branch compare:** selected by funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- **Redirect:** `pc_src` = valid & !busy & (jump | (branch & taken)).
- **Target:** `branch_target` = jalr ? (A_fwd + imm) & ~1 : PC + imm.
- **Divider FSM**, states IDLE → BUSY → DONE:
  - IDLE → BUSY on valid & muldiv & funct3[2] & not a special case. Latch operand magnitudes, sign flags and op; counter = 31.
  - BUSY: one restoring iteration per cycle (shift, trial-subtract). When counter reaches 0, go to DONE.
  - DONE: apply sign fix-ups, present the result, go to IDLE.
- **Divider special cases**, resolved in IDLE in one cycle with no stall:
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by -1: quotient = 0x80000000, remainder = 0.
- **Signs:** quotient is negative when operand signs differ; remainder takes the dividend's sign.
- **Stall:** `stall` = (IDLE & a new non-special divide) | BUSY.
- **Output register:**
  - `rst` or `flush`: all outputs 0, which makes them a bubble.
  - Else if `stall` or !valid: bubble (both write enables 0, `rd` 0, data 0).
  - Else: capture the result and the passthrough controls.
- **Flush during BUSY:** FSM returns to IDLE on the same edge; the partial result is discarded.

## Timing
- **Reset values:** every registered output is 0 and the FSM is in IDLE. `stall` and `pc_src` are 0 while `rst` is held.
- **ALU, multiply, branch:** 1-cycle latency. The result appears in `execute_*` after the next rising edge.
- **Divide, with the instruction first presented in cycle 0:**
  - `stall` is high in cycles 0–32 (33 cycles).
  - Cycle 33 is DONE, with `stall` low.
  - The result is registered at the end of cycle 33; 34 cycles occupancy in total.
- **Operand stability:** decode holds its inputs stable while `stall` = 1. Operands are latched on entering BUSY, so forwarding sources may change afterwards.
- **No redirect while busy:** `pc_src` is never asserted while `stall` = 1.
- **Flush priority:** `flush` has priority over all other behaviour in the same cycle.
- **Consecutive divides:** back-to-back divides re-enter BUSY from DONE → IDLE, leaving one non-stalled cycle between them.

## Structure
- **Shared package** `core_pkg`:
  - ALU op enum `alu_ctrl_e`.
  - Forward select constants.
  - `result_src` encodings.
  - Branch and M-extension funct3 constants.
- **Sub-module** `divider_seq`:
  - Owns the FSM, counter, special cases and sign fix-up.
  - Ports: `clk`, `rst`, `abort`, `start`, `op`, `a`, `b`, `busy`, `done`, `result`.

## Test plan
- **ADD:** ADD with rs1 = 5, rs2 = 7 → `execute_alu_result` = 12 and `execute_regfile_wr_enable` = 1 one cycle later.
- **Forwarding:** `forward_a` = 10 with `mem_alu_result` = 0x100, SUB with rs2 = 1 → result 0xFF; the stale rs1 value is ignored.
- **Branch:** BEQ at PC 0x40, imm 0x10, equal operands → `pc_src` = 1 and `branch_target` = 0x50 in the same cycle. With unequal operands → `pc_src` = 0.
- **Signed divide:** DIV -100 / 7 → `stall` high for exactly 33 cycles, then `execute_alu_result` = 0xFFFFFFF2 (-14). REM of the same operands → 0xFFFFFFFE (-2).
- **Special cases:** DIVU x / 0 → 0xFFFFFFFF with no stall. REM 0x80000000 / -1 → 0 with no stall.
- **Flush mid-divide:** assert `flush` in cycle 10 of a divide → `stall` low next cycle, outputs are a bubble, and a following ADD completes normally.
